// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: one-cycle registered copy of decode fields, with flush/stall bubbles and a saturating bubble counter.
// Latency 1 clk; stall holds the stage, flush or an invalid decode inserts a bubble. Optional rs1/rs2 fields via ID_EX_FWD_INFO_EN.
// All outputs come straight from flops; there is no input-to-output combinational path.
module id_ex_pipe_reg #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_rs1_data,
  input  logic [DATA_W-1:0]     id_rs2_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [3:0]            id_funct,
  input  logic [1:0]            id_alu_op,
  input  logic                  id_alu_src,
  input  logic                  id_branch,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_reg_write,
`ifdef ID_EX_FWD_INFO_EN
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
`endif
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_rs1_data,
  output logic [DATA_W-1:0]     ex_rs2_data,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [3:0]            ex_funct,
  output logic [1:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_reg_write,
  output logic [31:0]           bubble_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     rs1_data;
    logic [DATA_W-1:0]     rs2_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rd;
    logic [3:0]            funct;
    logic [1:0]            alu_op;
    logic                  alu_src;
    logic                  branch;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  reg_write;
`ifdef ID_EX_FWD_INFO_EN
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
`endif
  } stage_t;

  stage_t      id_st;
  stage_t      ex_st;
  logic [31:0] bubble_cnt_q;

  always_comb begin
    id_st            = '0;
    id_st.valid      = id_valid;
    id_st.pc         = id_pc;
    id_st.rs1_data   = id_rs1_data;
    id_st.rs2_data   = id_rs2_data;
    id_st.imm        = id_imm;
    id_st.rd         = id_rd;
    id_st.funct      = id_funct;
    id_st.alu_op     = id_alu_op;
    id_st.alu_src    = id_alu_src;
    id_st.branch     = id_branch;
    id_st.mem_read   = id_mem_read;
    id_st.mem_write  = id_mem_write;
    id_st.mem_to_reg = id_mem_to_reg;
    id_st.reg_write  = id_reg_write;
`ifdef ID_EX_FWD_INFO_EN
    id_st.rs1        = id_rs1;
    id_st.rs2        = id_rs2;
`endif
  end

  // A bubble is the all-zero stage: no writes, no branch, ALUOp=00 (add).
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_st        <= '0;
      bubble_cnt_q <= '0;
    end else if (flush || (!stall && !id_valid)) begin
      ex_st        <= '0;
      bubble_cnt_q <= (bubble_cnt_q == 32'hFFFF_FFFF) ? bubble_cnt_q : bubble_cnt_q + 32'd1;
    end else if (!stall) begin
      ex_st        <= id_st;
    end
  end

  assign ex_valid      = ex_st.valid;
  assign ex_pc         = ex_st.pc;
  assign ex_rs1_data   = ex_st.rs1_data;
  assign ex_rs2_data   = ex_st.rs2_data;
  assign ex_imm        = ex_st.imm;
  assign ex_rd         = ex_st.rd;
  assign ex_funct      = ex_st.funct;
  assign ex_alu_op     = ex_st.alu_op;
  assign ex_alu_src    = ex_st.alu_src;
  assign ex_branch     = ex_st.branch;
  assign ex_mem_read   = ex_st.mem_read;
  assign ex_mem_write  = ex_st.mem_write;
  assign ex_mem_to_reg = ex_st.mem_to_reg;
  assign ex_reg_write  = ex_st.reg_write;
`ifdef ID_EX_FWD_INFO_EN
  assign ex_rs1        = ex_st.rs1;
  assign ex_rs2        = ex_st.rs2;
`endif
  assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized bench for id_ex_pipe_reg against a rule-level stage model.
module tb_id_ex_pipe_reg;
  localparam int DW = 64;
  localparam int AW = 5;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [DW-1:0] imm;
    logic [AW-1:0] rd;
    logic [3:0]    funct;
    logic [1:0]    alu_op;
    logic          alu_src;
    logic          branch;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          reg_write;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
  } stage_t;

  logic   clk = 1'b0;
  logic   reset, stall, flush;
  stage_t in_st;
  stage_t exp_st;
  stage_t dut_st;
  logic [31:0] exp_cnt;
  int tests_run = 0;
  int fails = 0;

  logic          ex_valid, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic [DW-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [AW-1:0] ex_rd, ex_rs1, ex_rs2;
  logic [3:0]    ex_funct;
  logic [1:0]    ex_alu_op;
  logic [31:0]   bubble_cnt;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(in_st.valid), .id_pc(in_st.pc), .id_rs1_data(in_st.rs1_data),
    .id_rs2_data(in_st.rs2_data), .id_imm(in_st.imm), .id_rd(in_st.rd),
    .id_funct(in_st.funct), .id_alu_op(in_st.alu_op), .id_alu_src(in_st.alu_src),
    .id_branch(in_st.branch), .id_mem_read(in_st.mem_read), .id_mem_write(in_st.mem_write),
    .id_mem_to_reg(in_st.mem_to_reg), .id_reg_write(in_st.reg_write),
`ifdef ID_EX_FWD_INFO_EN
    .id_rs1(in_st.rs1), .id_rs2(in_st.rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
`endif
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .bubble_cnt(bubble_cnt)
  );

`ifndef ID_EX_FWD_INFO_EN
  assign ex_rs1 = '0;
  assign ex_rs2 = '0;
`endif

  assign dut_st = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_funct, ex_alu_op,
                   ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write,
                   ex_rs1, ex_rs2};

  // Without the forwarding option the rs1/rs2 fields never reach EX, so the model keeps them zero.
  function automatic stage_t visible(input stage_t s);
    stage_t r = s;
`ifndef ID_EX_FWD_INFO_EN
    r.rs1 = '0;
    r.rs2 = '0;
`endif
    return r;
  endfunction

  task automatic rand_inputs(input int valid_pct);
    in_st.valid      = ($urandom_range(99) < valid_pct);
    in_st.pc         = {$urandom, $urandom} | 64'h1;
    in_st.rs1_data   = {$urandom, $urandom} | 64'h1;
    in_st.rs2_data   = {$urandom, $urandom} | 64'h1;
    in_st.imm        = {$urandom, $urandom} | 64'h1;
    in_st.rd         = AW'($urandom_range(1, 31));
    in_st.funct      = 4'($urandom_range(1, 15));
    in_st.alu_op     = 2'($urandom_range(1, 3));
    {in_st.alu_src, in_st.branch, in_st.mem_read, in_st.mem_write, in_st.mem_to_reg,
     in_st.reg_write} = 6'($urandom_range(1, 63));
    in_st.rs1        = AW'($urandom_range(1, 31));
    in_st.rs2        = AW'($urandom_range(1, 31));
  endtask

  // Advance one edge and apply the stage rules: reset > flush > stall > load.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      exp_st  = '0;
      exp_cnt = '0;
    end else if (flush || (!stall && !in_st.valid)) begin
      exp_st = '0;
      if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
    end else if (!stall) begin
      exp_st = visible(in_st);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      rand_inputs(100);
      reset = 1'b1; stall = 1'b1; flush = 1'b1;
      tick();
      tests_run++;
      if (dut_st !== '0 || bubble_cnt !== 32'd0) begin
        fails++;
        $display("FAIL reset cycle %0d: got %h cnt %h, want zero", c, dut_st, bubble_cnt);
      end
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_load();
    rand_inputs(100);
    in_st.alu_op = 2'b10; in_st.funct = 4'b1000; in_st.rd = 5; in_st.imm = 64'h10;
    tick();
    tests_run++;
    if (ex_alu_op !== 2'b10 || ex_funct !== 4'b1000 || ex_rd !== 5'd5 || ex_imm !== 64'h10 || ex_valid !== 1'b1) begin
      fails++;
      $display("FAIL load fields: alu_op %b funct %b rd %0d imm %h valid %b, want 10 1000 5 10 1",
               ex_alu_op, ex_funct, ex_rd, ex_imm, ex_valid);
    end
    tests_run++;
    if (dut_st !== exp_st) begin
      fails++;
      $display("FAIL load stage: got %h want %h", dut_st, exp_st);
    end
  endtask

  task automatic test_stall();
    stage_t held;
    logic [31:0] cnt0;
    rand_inputs(100);
    tick();
    held = dut_st;
    cnt0 = bubble_cnt;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_inputs(50);
      tick();
      tests_run++;
      if (dut_st !== exp_st || bubble_cnt !== exp_cnt || dut_st !== held || bubble_cnt !== cnt0) begin
        fails++;
        $display("FAIL stall hold %0d: got %h cnt %h want %h cnt %h", c, dut_st, bubble_cnt, exp_st, exp_cnt);
      end
    end
    stall = 1'b0;
  endtask

  task automatic test_stall_flush();
    logic [31:0] cnt0;
    rand_inputs(100);
    tick();
    cnt0 = bubble_cnt;
    rand_inputs(100);
    stall = 1'b1; flush = 1'b1;
    tick();
    tests_run++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_alu_op !== 2'b00 || dut_st !== '0 ||
        bubble_cnt !== cnt0 + 32'd1) begin
      fails++;
      $display("FAIL stall_flush: got %h cnt %h want zero cnt %h", dut_st, bubble_cnt, cnt0 + 32'd1);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_count_saturate();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      rand_inputs(0);
      tick();
      tests_run++;
      if (bubble_cnt !== 32'(c) || ex_valid !== 1'b0) begin
        fails++;
        $display("FAIL invalid_count %0d: got %0d valid %b want %0d valid 0", c, bubble_cnt, ex_valid, c);
      end
    end
    dut.bubble_cnt_q = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    for (int c = 0; c < 2; c++) begin
      rand_inputs(100);
      flush = 1'b1;
      tick();
      tests_run++;
      if (bubble_cnt !== 32'hFFFF_FFFF) begin
        fails++;
        $display("FAIL saturate %0d: got %h want ffffffff", c, bubble_cnt);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    rand_inputs(100);
    tick();
    stall = 1'b1; reset = 1'b1;
    tick();
    tests_run++;
    if (dut_st !== '0 || bubble_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid_stall: got %h cnt %h want zero", dut_st, bubble_cnt);
    end
    reset = 1'b0; stall = 1'b0;
    rand_inputs(100);
    tick();
    tests_run++;
    if (dut_st !== exp_st || ex_valid !== 1'b1) begin
      fails++;
      $display("FAIL after_reset_load: got %h want %h", dut_st, exp_st);
    end
  endtask

`ifdef ID_EX_FWD_INFO_EN
  task automatic test_fwd();
    rand_inputs(100);
    in_st.rs1 = 3; in_st.rs2 = 7;
    tick();
    tests_run++;
    if (ex_rs1 !== 5'd3 || ex_rs2 !== 5'd7) begin
      fails++;
      $display("FAIL fwd_load: got rs1 %0d rs2 %0d want 3 7", ex_rs1, ex_rs2);
    end
    flush = 1'b1;
    tick();
    tests_run++;
    if (ex_rs1 !== '0 || ex_rs2 !== '0) begin
      fails++;
      $display("FAIL fwd_flush: got rs1 %0d rs2 %0d want 0 0", ex_rs1, ex_rs2);
    end
    flush = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_inputs(75);
      reset = ($urandom_range(99) < 3);
      stall = ($urandom_range(99) < 30);
      flush = ($urandom_range(99) < 15);
      tick();
      tests_run++;
      if (dut_st !== exp_st || bubble_cnt !== exp_cnt) begin
        fails++;
        $display("FAIL random %0d: got %h cnt %h want %h cnt %h", c, dut_st, bubble_cnt, exp_st, exp_cnt);
      end
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    exp_st  = '0;
    exp_cnt = '0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    in_st = '0;
    test_reset();
    test_load();
    test_stall();
    test_stall_flush();
    test_count_saturate();
    test_reset_mid_stall();
`ifdef ID_EX_FWD_INFO_EN
    test_fwd();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 Parameter DATA_W, 64: width of the PC, register-data and immediate fields.
REQ-002 Parameter REG_ADDR_W, 5: width of register-index fields.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold all stage contents this cycle.
REQ-006 flush  input  1  replace the stage contents with a bubble this cycle.
REQ-007 id_valid  input  1  decode stage holds a real instruction.
REQ-008 id_pc, id_rs1_data, id_rs2_data, id_imm  input  DATA_W each  decode-stage datapath values.
REQ-009 id_rd  input  REG_ADDR_W  destination register index.
REQ-010 id_funct  input  4  {instr[30], instr[14:12]}, passed unmodified to the EX-stage ALU control.
REQ-011 id_alu_op  input  2  ALU operation class (00 add/addr, 01 branch-sub, 10 R-type).
REQ-012 id_alu_src, id_branch, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write  input  1 each  decode control bits.
REQ-013 ex_* outputs  output  same widths  registered copies of every id_* field above, including ex_valid.
REQ-014 bubble_cnt  output  32  count of bubbles inserted into EX.

Function
REQ-015 Every ex_* output SHALL be driven only from flops; latency id_* to ex_* SHALL be exactly one clk cycle.
REQ-016 Per-edge priority SHALL be: reset > flush > stall > load.
REQ-017 Load (no reset/flush/stall, id_valid=1): all ex_* SHALL take the id_* values; ex_valid=1.
REQ-018 Bubble: ex_valid, ex_alu_op, ex_alu_src, ex_branch, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_funct, ex_rd SHALL be 0; datapath fields (pc, rs1/rs2 data, imm) SHALL be 0.
REQ-019 flush=1 SHALL produce a bubble regardless of stall or id_valid.
REQ-020 Load with id_valid=0 SHALL produce a bubble.
REQ-021 stall=1, flush=0 SHALL hold every ex_* output and bubble_cnt unchanged.
REQ-022 bubble_cnt SHALL increment by 1 on each edge that produces a bubble via REQ-019 or REQ-020; it SHALL saturate at 32'hFFFF_FFFF without wrapping.
REQ-023 A bubble SHALL never assert ex_reg_write, ex_mem_write or ex_branch; downstream ALU control sees ALUOp=00 (add).
REQ-024 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-025 On a clk edge with reset=1, all ex_* outputs and bubble_cnt SHALL be 0, independent of stall/flush.
REQ-026 Reset asserted mid-stall SHALL discard held contents; first edge after reset deassertion SHALL follow REQ-016 normally.

Configuration
REQ-027 Macro ID_EX_FWD_INFO_EN: when defined, ports id_rs1, id_rs2 (input, REG_ADDR_W) and ex_rs1, ex_rs2 (output, REG_ADDR_W) SHALL exist, follow REQ-017/018/021/025 (0 on bubble/reset), and feed the forwarding unit.
REQ-028 When ID_EX_FWD_INFO_EN is undefined those four ports and their flops SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 reset=1 two cycles with all inputs at random nonzero values -> every ex_* = 0, bubble_cnt = 0.
REQ-030 id_valid=1, id_alu_op=2'b10, id_funct=4'b1000, id_rd=5, id_imm=64'h10 loaded -> next cycle ex_alu_op=10, ex_funct=1000, ex_rd=5, ex_imm=64'h10, ex_valid=1.
REQ-031 After a load, stall=1 for 3 cycles while id_* change -> ex_* unchanged all 3 cycles, bubble_cnt unchanged.
REQ-032 stall=1 and flush=1 same edge -> bubble (ex_valid=0, ex_reg_write=0, ex_alu_op=00), bubble_cnt +1.
REQ-033 id_valid=0 for 4 consecutive loads from bubble_cnt=0 -> bubble_cnt=4; force bubble_cnt to 32'hFFFF_FFFF then one flush -> stays 32'hFFFF_FFFF.
REQ-034 With ID_EX_FWD_INFO_EN defined, id_rs1=3, id_rs2=7 loaded -> ex_rs1=3, ex_rs2=7; next edge with flush=1 -> both 0.
